// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   - seq_state_t : FSM encoding (IDLE=0, RUN=1, STEP=2, HALT=3)
//   - COND_*      : 4-bit jump condition codes
//   - FLAG_*      : bit positions of {Z,N,C,V} within the flag vector
//   - cond_taken  : combinational jump-condition evaluation on a flag vector
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } seq_state_t;

    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_EQ     = 4'd1;
    localparam logic [3:0] COND_NE     = 4'd2;
    localparam logic [3:0] COND_GT     = 4'd3;
    localparam logic [3:0] COND_LT     = 4'd4;
    localparam logic [3:0] COND_GE     = 4'd5;
    localparam logic [3:0] COND_LE     = 4'd6;
    localparam logic [3:0] COND_CS     = 4'd7;
    localparam logic [3:0] COND_VS     = 4'd8;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Codes 9..15 are reserved and never taken.
    function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] flg);
        logic z, n, c, v, res;
        z = flg[FLAG_Z];
        n = flg[FLAG_N];
        c = flg[FLAG_C];
        v = flg[FLAG_V];
        case (cond)
            COND_ALWAYS: res = 1'b1;
            COND_EQ:     res = z;
            COND_NE:     res = ~z;
            COND_GT:     res = ~z & ~n;
            COND_LT:     res = n;
            COND_GE:     res = ~n;
            COND_LE:     res = z | n;
            COND_CS:     res = c;
            COND_VS:     res = v;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: LIFO of return addresses for CALL/RET.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointer only; storage is not reset)
//   i_push      write i_data on top (ignored when full)
//   i_pop       discard top entry (ignored when empty)
//   i_data      address to push
//   o_top       current top entry (undefined when empty)
//   o_full      DEPTH entries held
//   o_empty     no entries held
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    // Count has one extra bit so that full and empty are distinguishable.
    logic [PTR_W:0]     r_cnt;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   w_wr_idx;
    logic [PTR_W-1:0]   w_top_idx;

    assign w_wr_idx  = r_cnt[PTR_W-1:0];
    assign w_top_idx = w_wr_idx - PTR_W'(1);
    assign o_full    = (r_cnt == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_top     = r_mem[w_top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_push && !o_full) begin
            r_cnt <= r_cnt + (PTR_W+1)'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, flag register and run/halt sequencing of the 8-bit CPU.
// Optional feature macro: PC_SEQ_CALL_STACK_EN (return-address stack for CALL/RET).
//   Without it, is_call/is_ret are ignored and stack_err stays 0.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   level: execute continuously
//   step                  pulse: execute one instruction while paused
//   is_jump, jump_cond    jump decode and condition code (COND_*)
//   jump_target           absolute target for jumps and calls
//   is_call, is_ret       CALL / RET decode
//   halt_req              HALT decode
//   flags_write,alu_flags flag update strobe and ALU {Z,N,C,V}
//   pc                    current instruction address
//   exec_en               current instruction commits this cycle
//   flags                 registered {Z,N,C,V}
//   state                 FSM state
//   stack_err             sticky stack overflow/underflow
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step,
    input  logic                is_jump,
    input  logic [3:0]          jump_cond,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                is_call,
    input  logic                is_ret,
    input  logic                halt_req,
    input  logic                flags_write,
    input  logic [3:0]          alu_flags,
    output logic [PC_WIDTH-1:0] pc,
    output logic                exec_en,
    output logic [3:0]          flags,
    output logic [1:0]          state,
    output logic                stack_err
);
    seq_state_t          r_state, w_state_next;
    logic [PC_WIDTH-1:0] r_pc, w_pc_next, w_pc_inc;
    logic [3:0]          r_flags;
    logic                r_stack_err;
    logic                w_exec;
    logic                w_jump_taken;
    logic                w_do_call, w_do_ret, w_stk_err;
    logic [PC_WIDTH-1:0] w_stk_top;

    // RUN only commits while run is still held; dropping run pauses before this instruction.
    assign w_exec       = ((r_state == ST_RUN) && run) || (r_state == ST_STEP);
    assign w_pc_inc     = r_pc + PC_WIDTH'(1);
    // Registered flags only: a flag write in this same cycle is not yet visible.
    assign w_jump_taken = is_jump && cond_taken(jump_cond, r_flags);

`ifdef PC_SEQ_CALL_STACK_EN
    logic w_stk_full, w_stk_empty, w_push, w_pop;

    // halt_req outranks RET, which outranks CALL.
    assign w_do_ret  = w_exec && !halt_req && is_ret;
    assign w_do_call = w_exec && !halt_req && !is_ret && is_call;
    assign w_push    = w_do_call && !w_stk_full;
    assign w_pop     = w_do_ret && !w_stk_empty;
    assign w_stk_err = (w_do_ret && w_stk_empty) || (w_do_call && w_stk_full);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_ret_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );
`else
    logic w_unused_ctrl;

    assign w_do_ret      = 1'b0;
    assign w_do_call     = 1'b0;
    assign w_stk_err     = 1'b0;
    assign w_stk_top     = '0;
    assign w_unused_ctrl = ^{is_call, is_ret, STACK_DEPTH[0]};
`endif

    always_comb begin
        w_pc_next = r_pc;
        if (w_exec && !halt_req) begin
            if (w_do_ret) begin
                w_pc_next = w_stk_err ? r_pc : w_stk_top;
            end else if (w_do_call) begin
                w_pc_next = w_stk_err ? r_pc : jump_target;
            end else if (w_jump_taken) begin
                w_pc_next = jump_target;
            end else begin
                w_pc_next = w_pc_inc;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_next = ST_RUN;
                end else if (step) begin
                    w_state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    w_state_next = ST_IDLE;
                end else if (halt_req || w_stk_err) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_STEP: begin
                if (halt_req || w_stk_err) begin
                    w_state_next = ST_HALT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_flags     <= '0;
            r_stack_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_stack_err <= r_stack_err || w_stk_err;
            if (w_exec && flags_write) begin
                r_flags <= alu_flags;
            end
        end
    end

    assign pc        = r_pc;
    assign exec_en   = w_exec;
    assign flags     = r_flags;
    assign state     = r_state;
    assign stack_err = r_stack_err;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, step, is_jump, is_call, is_ret, halt_req, flags_write;
    logic [3:0] jump_cond, alu_flags;
    logic [7:0] jump_target;
    logic [7:0] pc;
    logic       exec_en;
    logic [3:0] flags;
    logic [1:0] state;
    logic       stack_err;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALT = 2'd3;

    pc_sequencer #(.PC_WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .is_jump(is_jump),
        .jump_cond(jump_cond), .jump_target(jump_target), .is_call(is_call),
        .is_ret(is_ret), .halt_req(halt_req), .flags_write(flags_write),
        .alu_flags(alu_flags), .pc(pc), .exec_en(exec_en), .flags(flags),
        .state(state), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic clr_ctrl();
        step = 0; is_jump = 0; jump_cond = 0; jump_target = 0;
        is_call = 0; is_ret = 0; halt_req = 0; flags_write = 0; alu_flags = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_ctrl();
        run = 0;
        rst_n = 0;
        #3;
        rst_n = 1;
        tick();
    endtask

    // Enter RUN and jump to target so the next instruction is at 'target'.
    task automatic goto_run(input logic [7:0] target);
        run = 1;
        tick();
        is_jump = 1; jump_cond = 4'd0; jump_target = target;
        tick();
        clr_ctrl();
    endtask

    task automatic test_reset();
        clr_ctrl();
        run = 0;
        rst_n = 0;
        #1;
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
        checks++; if (state !== S_IDLE || exec_en !== 1'b0 || stack_err !== 1'b0 || flags !== 4'h0) begin
            errors++; $display("FAIL reset_state: state=%0d exec_en=%b stack_err=%b flags=%h want 0/0/0/0", state, exec_en, stack_err, flags);
        end
        #3; rst_n = 1;
        tick();
        run = 1;
        tick();
        is_jump = 1; jump_cond = 4'd0; jump_target = 8'h2A;
        flags_write = 1; alu_flags = 4'hF;
        tick();
        clr_ctrl();
        checks++; if (pc !== 8'h2A || flags !== 4'hF || state !== S_RUN) begin
            errors++; $display("FAIL pre_reset: pc=%h flags=%h state=%0d want 2a f 1", pc, flags, state);
        end
        #2;
        rst_n = 0;
        #1;
        checks++; if (pc !== 8'h00 || flags !== 4'h0) begin
            errors++; $display("FAIL async_reset_pc_flags: pc=%h flags=%h want 00 0", pc, flags);
        end
        checks++; if (state !== S_IDLE || exec_en !== 1'b0) begin
            errors++; $display("FAIL async_reset_state: state=%0d exec_en=%b want 0 0", state, exec_en);
        end
        run = 0;
        #1; rst_n = 1;
        tick();
    endtask

    task automatic test_count_wrap();
        logic [7:0] exp_pc [3];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
        do_reset();
        goto_run(8'hFE);
        for (int i = 0; i < 3; i++) begin
            checks++; if (pc !== exp_pc[i] || exec_en !== 1'b1) begin
                errors++; $display("FAIL count_%0d: pc=%h exec_en=%b want %h 1", i, pc, exec_en, exp_pc[i]);
            end
            if (i < 2) tick();
        end
        run = 0;
        #1;
        checks++; if (exec_en !== 1'b0) begin errors++; $display("FAIL run_drop_exec: got %b want 0", exec_en); end
        tick();
        checks++; if (pc !== 8'h00 || state !== S_IDLE) begin
            errors++; $display("FAIL run_drop_hold: pc=%h state=%0d want 00 0", pc, state);
        end
    endtask

    task automatic test_flags_jump();
        do_reset();
        run = 1;
        tick();
        // flag write and JEQ in the same cycle: old flags (0) -> not taken
        flags_write = 1; alu_flags = 4'b1000;
        is_jump = 1; jump_cond = 4'd1; jump_target = 8'h40;
        tick();
        clr_ctrl();
        checks++; if (pc !== 8'h01 || flags !== 4'b1000) begin
            errors++; $display("FAIL jeq_same_cycle: pc=%h flags=%h want 01 8", pc, flags);
        end
        is_jump = 1; jump_cond = 4'd1; jump_target = 8'h40;
        tick();
        checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jeq_taken: pc=%h want 40", pc); end
        jump_cond = 4'd2; jump_target = 8'h90;
        tick();
        checks++; if (pc !== 8'h41) begin errors++; $display("FAIL jne_not_taken: pc=%h want 41", pc); end
        // Set N while JLT sees old Z-only flags
        flags_write = 1; alu_flags = 4'b0100; jump_cond = 4'd4; jump_target = 8'h70;
        tick();
        flags_write = 0;
        checks++; if (pc !== 8'h42) begin errors++; $display("FAIL jlt_old_flags: pc=%h want 42", pc); end
        tick();
        checks++; if (pc !== 8'h70) begin errors++; $display("FAIL jlt_taken: pc=%h want 70", pc); end
        jump_cond = 4'd3; jump_target = 8'h10;
        tick();
        checks++; if (pc !== 8'h71) begin errors++; $display("FAIL jgt_not_taken: pc=%h want 71", pc); end
        jump_cond = 4'd9; jump_target = 8'h10;
        tick();
        checks++; if (pc !== 8'h72) begin errors++; $display("FAIL cond9_never: pc=%h want 72", pc); end
        is_jump = 0; flags_write = 1; alu_flags = 4'b0010;
        tick();
        flags_write = 0; is_jump = 1; jump_cond = 4'd7; jump_target = 8'h80;
        tick();
        checks++; if (pc !== 8'h80) begin errors++; $display("FAIL jcs_taken: pc=%h want 80", pc); end
        jump_cond = 4'd8; jump_target = 8'h90;
        tick();
        checks++; if (pc !== 8'h81) begin errors++; $display("FAIL jvs_not_taken: pc=%h want 81", pc); end
        clr_ctrl();
    endtask

    task automatic test_step();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step = 1;
            tick();
            step = 0;
            checks++; if (state !== S_STEP || exec_en !== 1'b1 || pc !== 8'(i)) begin
                errors++; $display("FAIL step_enter_%0d: state=%0d exec_en=%b pc=%h want 2 1 %h", i, state, exec_en, pc, 8'(i));
            end
            tick();
            checks++; if (state !== S_IDLE || exec_en !== 1'b0 || pc !== 8'(i + 1)) begin
                errors++; $display("FAIL step_done_%0d: state=%0d exec_en=%b pc=%h want 0 0 %h", i, state, exec_en, pc, 8'(i + 1));
            end
        end
        tick(); tick();
        checks++; if (pc !== 8'h04 || exec_en !== 1'b0) begin
            errors++; $display("FAIL step_idle_hold: pc=%h exec_en=%b want 04 0", pc, exec_en);
        end
        step = 1; run = 1;
        tick();
        step = 0;
        checks++; if (state !== S_RUN) begin errors++; $display("FAIL step_and_run: state=%0d want 1", state); end
        run = 0;
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        goto_run(8'h07);
        halt_req = 1;
        tick();
        halt_req = 0;
        checks++; if (pc !== 8'h07 || state !== S_HALT || exec_en !== 1'b0) begin
            errors++; $display("FAIL halt_enter: pc=%h state=%0d exec_en=%b want 07 3 0", pc, state, exec_en);
        end
        step = 1; is_jump = 1; jump_target = 8'h33;
        tick();
        step = 0;
        tick(); tick();
        checks++; if (pc !== 8'h07 || state !== S_HALT || exec_en !== 1'b0) begin
            errors++; $display("FAIL halt_sticky: pc=%h state=%0d exec_en=%b want 07 3 0", pc, state, exec_en);
        end
        do_reset();
        checks++; if (state !== S_IDLE || pc !== 8'h00) begin
            errors++; $display("FAIL halt_exit_reset: state=%0d pc=%h want 0 00", state, pc);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        goto_run(8'h05);
        is_call = 1; jump_target = 8'h10;
        tick();
        is_call = 0;
`ifdef PC_SEQ_CALL_STACK_EN
        checks++; if (pc !== 8'h10) begin errors++; $display("FAIL call: pc=%h want 10", pc); end
        is_ret = 1;
        tick();
        is_ret = 0;
        checks++; if (pc !== 8'h06 || stack_err !== 1'b0) begin
            errors++; $display("FAIL ret: pc=%h stack_err=%b want 06 0", pc, stack_err);
        end
        is_call = 1; jump_target = 8'h20;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (pc !== 8'h20 || state !== S_RUN || stack_err !== 1'b0) begin
            errors++; $display("FAIL call_depth4: pc=%h state=%0d err=%b want 20 1 0", pc, state, stack_err);
        end
        tick();
        is_call = 0;
        checks++; if (pc !== 8'h20 || state !== S_HALT || stack_err !== 1'b1) begin
            errors++; $display("FAIL call_overflow: pc=%h state=%0d err=%b want 20 3 1", pc, state, stack_err);
        end
        do_reset();
        goto_run(8'h09);
        is_ret = 1;
        tick();
        is_ret = 0;
        checks++; if (pc !== 8'h09 || state !== S_HALT || stack_err !== 1'b1) begin
            errors++; $display("FAIL ret_underflow: pc=%h state=%0d err=%b want 09 3 1", pc, state, stack_err);
        end
`else
        checks++; if (pc !== 8'h06) begin errors++; $display("FAIL call_ignored: pc=%h want 06", pc); end
        is_ret = 1;
        tick();
        is_ret = 0;
        checks++; if (pc !== 8'h07 || stack_err !== 1'b0 || state !== S_RUN) begin
            errors++; $display("FAIL ret_ignored: pc=%h err=%b state=%0d want 07 0 1", pc, stack_err, state);
        end
`endif
        do_reset();
    endtask

    initial begin
        rst_n = 1; run = 0;
        clr_ctrl();
        test_reset();
        test_count_wrap();
        test_flags_jump();
        test_step();
        test_halt();
        test_call_ret();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
